// File: rtl/event_counter_pkg.sv
// Shared definitions for the event_counter slice: FSM state encoding and
// default widths.
package event_counter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_WIN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/event_counter_sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector. This block can be
// reused for any asynchronous single-bit input.
module sync_edge_det (
  input  logic clk,
  input  logic clr_n,
  input  logic async_in,
  output logic rise
);

  logic s_p0;
  logic s_p1;
  logic s_p2;

  // s_p0/s_p1 form the metastability chain; s_p2 holds the previous synced level
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s_p0 <= 1'b0;
      s_p1 <= 1'b0;
      s_p2 <= 1'b0;
    end else begin
      s_p0 <= async_in;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign rise = s_p1 & ~s_p2;

endmodule

// File: rtl/event_counter.sv
// Counts rising edges of an asynchronous input over a programmable window of
// clk cycles and presents the saturated result through a valid/ack handshake.
module event_counter
  import event_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             event_in,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);

  state_t           state;
  logic [WIN_W-1:0] timer;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic             rise;
  logic [WIDTH:0]   inc_res;

  // Returns {saturated, next_value}; at full scale an increment is absorbed.
  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH-1:0] a,
                                             input logic             inc);
    if (inc && (a == {WIDTH{1'b1}}))
      return {1'b1, a};
    else
      return {1'b0, a + WIDTH'(inc)};
  endfunction

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .clr_n    (clr_n),
    .async_in (event_in),
    .rise     (rise)
  );

  assign inc_res = sat_inc(acc, rise);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      timer    <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (window != '0)) begin
            timer <= window;
            acc   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          timer <= timer - WIN_W'(1);
          // Last window cycle: fold this cycle's edge straight into the capture
          if (timer == WIN_W'(1)) begin
            count    <= inc_res[WIDTH-1:0];
            overflow <= ovf | inc_res[WIDTH];
            valid    <= 1'b1;
            state    <= HOLD;
          end else begin
            acc <= inc_res[WIDTH-1:0];
            ovf <= ovf | inc_res[WIDTH];
          end
        end
        HOLD: begin
          if (ack) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_counter.sv
// Scoreboard bench for event_counter: expected results queued at stimulus,
// popped and compared when valid appears.
module tb_event_counter;

  localparam int WIDTH = 8;
  localparam int WIN_W = 16;

  logic             clk;
  logic             clr_n;
  logic             event_in;
  logic             start;
  logic [WIN_W-1:0] window;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic             overflow;
  logic             valid;
  logic             busy;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  event_counter #(.WIDTH(WIDTH), .WIN_W(WIN_W)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .event_in (event_in),
    .start    (start),
    .window   (window),
    .ack      (ack),
    .count    (count),
    .overflow (overflow),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Start a measurement, drive a pulse train from the cycle after acceptance,
  // wait (bounded) for valid and compare against the scoreboard.
  task automatic run_meas(input int win, input int npulse, input int hi, input int lo,
                          input int exp_cnt, input int exp_ovf);
    exp_t e;
    int   lat;
    int   per;
    e.cnt = WIDTH'(exp_cnt);
    e.ovf = exp_ovf[0];
    sb_q.push_back(e);
    per = hi + lo;
    @(negedge clk);
    window = WIN_W'(win);
    start  = 1'b1;
    @(posedge clk);
    lat = 1;
    for (int k = 0; k < win + 10; k++) begin
      @(negedge clk);
      start    = 1'b0;
      event_in = (k < npulse * per) && ((k % per) < hi);
      @(posedge clk);
      #1;
      lat++;
      if (valid) break;
    end
    event_in = 1'b0;
    chk("latency", lat, win + 1);
    chk("busy_in_hold", 32'(busy), 1);
    e = sb_q.pop_front();
    chk("count", 32'(count), 32'(e.cnt));
    chk("overflow", 32'(overflow), 32'(e.ovf));
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_valid_low", 32'(valid), 0);
    chk("ack_busy_low", 32'(busy), 0);
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    logic stable;
    clr_n    = 1'b0;
    start    = 1'b0;
    ack      = 1'b0;
    event_in = 1'b0;
    window   = '0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;

    // Basic measurement
    run_meas(20, 5, 2, 2, 5, 0);
    do_ack();

    // Asynchronous reset mid-run with event_in toggling
    @(negedge clk);
    window = WIN_W'(50);
    start  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start    = 1'b0;
      event_in = ~event_in;
    end
    #2;
    clr_n = 1'b0;
    #1;
    chk("amid_count", 32'(count), 0);
    chk("amid_overflow", 32'(overflow), 0);
    chk("amid_valid", 32'(valid), 0);
    chk("amid_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      event_in = ~event_in;
      @(posedge clk);
      #1;
      if (valid || busy || (count != '0) || overflow) seen = 1'b1;
    end
    chk("held_in_reset", 32'(seen), 0);
    @(negedge clk);
    clr_n    = 1'b1;
    event_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_busy", 32'(busy), 0);

    // Saturation, then a clean run clears the sticky flag
    run_meas(1200, 300, 2, 2, 255, 1);
    do_ack();
    run_meas(20, 5, 2, 2, 5, 0);
    do_ack();

    // Zero window is ignored
    @(negedge clk);
    window = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (busy || valid) seen = 1'b1;
    end
    chk("zero_win_idle", 32'(seen), 0);
    chk("zero_win_count", 32'(count), 5);
    chk("zero_win_ovf", 32'(overflow), 0);

    // Handshake: stall ack, start pulses ignored, then ack+start together
    run_meas(20, 3, 2, 2, 3, 0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start  = (i == 2) || (i == 5);
      window = WIN_W'(20);
      @(posedge clk);
      #1;
      if (!valid || !busy || (count != WIDTH'(3)) || overflow) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 1);
    @(negedge clk);
    ack   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("ackstart_valid", 32'(valid), 0);
    chk("ackstart_busy", 32'(busy), 0);
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (busy || valid) seen = 1'b1;
    end
    chk("no_restart", 32'(seen), 0);
    chk("count_kept", 32'(count), 3);

    // Abort with reset at cycle 7 of COUNT
    @(negedge clk);
    window = WIN_W'(20);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    event_in = 1'b1;
    repeat (6) @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("abort_busy_now", 32'(busy), 0);
    @(negedge clk);
    clr_n    = 1'b1;
    event_in = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 0);
    chk("abort_count", 32'(count), 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
